// File: rtl/uart_apb_pkg.sv
// Shared definitions for the APB-to-UART register slave: register offsets,
// FSM encoding and UER bit layout.
package uart_apb_pkg;

    // Word offsets (PADDR[3:2]) of the four registers
    localparam logic [1:0] REG_USR = 2'd0;
    localparam logic [1:0] REG_UWD = 2'd1;
    localparam logic [1:0] REG_URD = 2'd2;
    localparam logic [1:0] REG_UER = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } apb_state_t;

    localparam int UER_RX_UF   = 0;
    localparam int UER_TX_OF   = 1;
    localparam int UER_CNT_LSB = 2;
    localparam int UER_CNT_W   = 8;

    function automatic logic [31:0] pack_uer(input logic [UER_CNT_W-1:0] cnt,
                                             input logic tx_of, input logic rx_uf);
        logic [31:0] v;
        v = '0;
        v[UER_CNT_LSB +: UER_CNT_W] = cnt;
        v[UER_TX_OF] = tx_of;
        v[UER_RX_UF] = rx_uf;
        return v;
    endfunction

endpackage

// File: rtl/apb_uart_slave.sv
// APB3 slave exposing a UART's RX/TX FIFOs as four registers, with sticky
// error flags and a saturating dropped-write counter.
module apb_uart_slave
    import uart_apb_pkg::*;
#(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    input  logic [7:0]        RX_rdata,
    input  logic              RX_empty,
    output logic              RX_rd,
    output logic              TX_wr,
    output logic [7:0]        TX_wdata,
    input  logic              TX_full
);

    apb_state_t state_q, state_d;

    logic [1:0]           reg_q;
    logic                 write_q;
    logic [2:0]           clr_q;
    logic [7:0]           tx_wdata_q;
    logic [31:0]          prdata_q;
    logic                 pslverr_q;
    logic                 rx_uf_q, tx_of_q;
    logic [UER_CNT_W-1:0] drop_cnt_q;

    logic        start;
    logic        is_exec;
    logic        rdata_load;
    logic [31:0] rdata_d;
    logic        acc_err;
    logic        tx_push, rx_pop;
    logic        of_set, uf_set;
    logic [2:0]  uer_clr;

    logic unused_bits;
    assign unused_bits = ^{PADDR, PWDATA[31:8]};

    assign start = (state_q == ST_IDLE) && PSEL && PENABLE;
    // Gating with rst keeps a reset that lands mid-EXEC from strobing a FIFO
    assign is_exec = (state_q == ST_EXEC) && !rst;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (PSEL && PENABLE) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_load = 1'b0;
        rdata_d    = '0;
        acc_err    = 1'b0;
        tx_push    = 1'b0;
        rx_pop     = 1'b0;
        of_set     = 1'b0;
        uf_set     = 1'b0;
        uer_clr    = '0;
        if (is_exec) begin
            unique case (reg_q)
                REG_USR: begin
                    if (write_q) acc_err = 1'b1;
                    else begin
                        rdata_load = 1'b1;
                        rdata_d    = {30'b0, ~TX_full, ~RX_empty};
                    end
                end
                REG_UWD: begin
                    if (write_q) begin
                        if (TX_full) begin
                            acc_err = 1'b1;
                            of_set  = 1'b1;
                        end else begin
                            tx_push = 1'b1;
                        end
                    end else begin
                        acc_err    = 1'b1;
                        rdata_load = 1'b1;
                    end
                end
                REG_URD: begin
                    if (write_q) acc_err = 1'b1;
                    else if (RX_empty) begin
                        acc_err    = 1'b1;
                        uf_set     = 1'b1;
                        rdata_load = 1'b1;
                    end else begin
                        rx_pop     = 1'b1;
                        rdata_load = 1'b1;
                        rdata_d    = {24'b0, RX_rdata};
                    end
                end
                REG_UER: begin
                    if (write_q) uer_clr = clr_q;
                    else begin
                        rdata_load = 1'b1;
                        rdata_d    = pack_uer(drop_cnt_q, tx_of_q, rx_uf_q);
                    end
                end
                default: acc_err = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            reg_q      <= '0;
            write_q    <= 1'b0;
            clr_q      <= '0;
            tx_wdata_q <= '0;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            rx_uf_q    <= 1'b0;
            tx_of_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            pslverr_q <= acc_err;
            if (start) begin
                reg_q   <= PADDR[3:2];
                write_q <= PWRITE;
                clr_q   <= PWDATA[2:0];
                if (PWRITE && PADDR[3:2] == REG_UWD) tx_wdata_q <= PWDATA[7:0];
            end
            if (rdata_load) prdata_q <= rdata_d;
            // A set event in the same cycle as a write-1-clear wins
            rx_uf_q <= uf_set | (rx_uf_q & ~uer_clr[UER_RX_UF]);
            tx_of_q <= of_set | (tx_of_q & ~uer_clr[UER_TX_OF]);
            if (of_set) begin
                if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
            end else if (uer_clr[UER_CNT_LSB]) begin
                drop_cnt_q <= '0;
            end
        end
    end

    assign PRDATA   = prdata_q;
    assign PREADY   = (state_q == ST_RESP);
    assign PSLVERR  = pslverr_q;
    assign RX_rd    = rx_pop;
    assign TX_wr    = tx_push;
    assign TX_wdata = tx_wdata_q;

endmodule
